// File: rtl/upsample_ratio_tracker.sv
// Measures the in_valid strobe spacing and turns it into the upsampler step word round(2^24 / period).
// Optional window averaging over 2^AVG_LOG2 intervals is enabled by defining UPSAMPLE_RATIO_AVG_EN.
module upsample_ratio_tracker #(
    parameter int AVG_LOG2   = 4,
    parameter int MIN_PERIOD = 2,
    parameter int MAX_PERIOD = 1048576,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic signed [24:0] ratio,
    output logic               ratio_valid,
    output logic               locked,
    output logic        [23:0] period
);
`ifdef UPSAMPLE_RATIO_AVG_EN
    localparam int KLOG = AVG_LOG2;
`else
    localparam int KLOG = 0 * AVG_LOG2;
`endif
    localparam int          DW     = 25 + KLOG;
    localparam int          LCW    = $clog2(LOCK_COUNT + 1);
    localparam logic [23:0] MAX_M1 = 24'(MAX_PERIOD - 1);
    localparam logic [24:0] Q_MAX  = 25'h0FF_FFFF;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} div_state_e;

    logic           armed_q, armed_d;
    logic [23:0]    cnt_q, cnt_d;
    logic           close_q, close_d;
    logic [23:0]    n_q, n_d;
    logic           have_prev_q, have_prev_d;
    logic [23:0]    m_prev_q, m_prev_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           locked_q, locked_d;
    logic [23:0]    period_q, period_d;
    logic           timeout;
    logic           m_vld;
    logic [23:0]    m_val;
    logic [23:0]    m_diff;
`ifdef UPSAMPLE_RATIO_AVG_EN
    logic [23:0]     acc_q, acc_d;
    logic [KLOG-1:0] win_q, win_d;
    logic [24:0]     acc_sum;
`endif

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every target a default first, so no latch is inferred.
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        close_d     = 1'b0;
        n_d         = n_q;
        have_prev_d = have_prev_q;
        m_prev_d    = m_prev_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        period_d    = period_q;
        timeout     = 1'b0;
        m_vld       = 1'b0;
        m_val       = n_q;
        m_diff      = '0;
`ifdef UPSAMPLE_RATIO_AVG_EN
        acc_d   = acc_q;
        win_d   = win_q;
        acc_sum = {1'b0, acc_q} + {1'b0, n_q};
`endif
        // cnt_q holds the elapsed clocks minus one, so a strobe now closes N = cnt_q + 1.
        if (!armed_q) begin
            if (in_valid) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end
        end else if (in_valid) begin
            close_d = 1'b1;
            n_d     = cnt_q + 24'd1;
            cnt_d   = '0;
        end else if (cnt_q == MAX_M1) begin
            timeout = 1'b1;
            armed_d = 1'b0;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        if (close_q) begin
            if (n_q < 24'(MIN_PERIOD)) begin
                have_prev_d = 1'b0;
                lock_cnt_d  = '0;
                locked_d    = 1'b0;
            end else begin
`ifdef UPSAMPLE_RATIO_AVG_EN
                if (acc_sum[24]) begin
                    // A wrapped window sum behaves exactly like a counter timeout.
                    timeout = 1'b1;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    close_d = 1'b0;
                end else if (&win_q) begin
                    m_vld = 1'b1;
                    m_val = acc_sum[23:0];
                    acc_d = '0;
                    win_d = '0;
                end else begin
                    acc_d = acc_sum[23:0];
                    win_d = win_q + KLOG'(1);
                end
`else
                m_vld = 1'b1;
`endif
            end
        end

        if (timeout) begin
            have_prev_d = 1'b0;
            lock_cnt_d  = '0;
            locked_d    = 1'b0;
`ifdef UPSAMPLE_RATIO_AVG_EN
            acc_d = '0;
            win_d = '0;
`endif
        end

        if (m_vld) begin
            m_diff = (m_val >= m_prev_q) ? (m_val - m_prev_q) : (m_prev_q - m_val);
            if (!have_prev_q || m_diff > 24'(TOL)) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LCW'(LOCK_COUNT)) begin
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
            locked_d    = (lock_cnt_d == LCW'(LOCK_COUNT));
            have_prev_d = 1'b1;
            m_prev_d    = m_val;
            period_d    = m_val;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (reset) begin
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            close_q     <= 1'b0;
            n_q         <= '0;
            have_prev_q <= 1'b0;
            m_prev_q    <= '0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            period_q    <= '0;
`ifdef UPSAMPLE_RATIO_AVG_EN
            acc_q <= '0;
            win_q <= '0;
`endif
        end else begin
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            close_q     <= close_d;
            n_q         <= n_d;
            have_prev_q <= have_prev_d;
            m_prev_q    <= m_prev_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            period_q    <= period_d;
`ifdef UPSAMPLE_RATIO_AVG_EN
            acc_q <= acc_d;
            win_q <= win_d;
`endif
        end
    end

    div_state_e         state_q;
    logic [23:0]        op_q;
    logic [23:0]        pend_q;
    logic               pend_vld_q;
    logic [23:0]        rem_q;
    logic [24:0]        quo_q;
    logic [4:0]         bit_q;
    logic signed [24:0] ratio_q;
    logic               ratio_valid_q;
    logic [DW-1:0]      dividend;
    logic [24:0]        trial;

    // Quotient fits in 25 bits, so the dividend bits above bit 24 seed the remainder.
    assign dividend = (DW'(1) << (24 + KLOG)) + DW'(op_q >> 1);
    assign trial    = {rem_q, quo_q[24]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_vld_q    <= 1'b0;
            ratio_q       <= '0;
            ratio_valid_q <= 1'b0;
        end else begin
            ratio_valid_q <= 1'b0;
            if (m_vld && (state_q == LOAD || state_q == DIV)) begin
                pend_q     <= m_val;
                pend_vld_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (m_vld) begin
                        op_q    <= m_val;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    rem_q   <= 24'(dividend >> 25);
                    quo_q   <= dividend[24:0];
                    bit_q   <= '0;
                    state_q <= DIV;
                end
                DIV: begin
                    if (trial >= {1'b0, op_q}) begin
                        rem_q <= 24'(trial - {1'b0, op_q});
                        quo_q <= {quo_q[23:0], 1'b1};
                    end else begin
                        rem_q <= trial[23:0];
                        quo_q <= {quo_q[23:0], 1'b0};
                    end
                    bit_q <= bit_q + 5'd1;
                    if (bit_q == 5'd24) state_q <= DONE;
                end
                DONE: begin
                    ratio_q       <= $signed((quo_q > Q_MAX) ? Q_MAX : quo_q);
                    ratio_valid_q <= 1'b1;
                    if (m_vld) begin
                        op_q       <= m_val;
                        pend_vld_q <= 1'b0;
                        state_q    <= LOAD;
                    end else if (pend_vld_q) begin
                        op_q       <= pend_q;
                        pend_vld_q <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // NOTE: divider datapath registers (op, pend, rem, quo, bit) have no reset; each is written before it is read.

    assign ratio       = ratio_q;
    assign ratio_valid = ratio_valid_q;
    assign locked      = locked_q;
    assign period      = period_q;

endmodule

// File: tb/tb_upsample_ratio_tracker.sv
// Drives directed and random strobe patterns and compares every cycle against a
// timestamp-based reference model of interval measurement, lock and divider scheduling.
module tb_upsample_ratio_tracker;
    localparam int AVG_LOG2   = 4;
    localparam int MIN_PERIOD = 2;
    localparam int MAX_PERIOD = 300;
    localparam int TOL        = 2;
    localparam int LOCK_COUNT = 8;
`ifdef UPSAMPLE_RATIO_AVG_EN
    localparam int K = 1 << AVG_LOG2;
`else
    localparam int K = 1;
`endif

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [24:0] ratio;
    logic               ratio_valid;
    logic               locked;
    logic        [23:0] period;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    upsample_ratio_tracker #(
        .AVG_LOG2  (AVG_LOG2),
        .MIN_PERIOD(MIN_PERIOD),
        .MAX_PERIOD(MAX_PERIOD),
        .TOL       (TOL),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .ratio      (ratio),
        .ratio_valid(ratio_valid),
        .locked     (locked),
        .period     (period)
    );

    always #5 clk = ~clk;

    // Reference model state: timestamps of strobes, a window sum, and divider job times.
    bit     m_armed, m_close, m_have_prev, m_busy, m_pend;
    int     m_last, m_close_n, m_prev, m_lock_cnt, m_win_sum, m_win_n;
    int     m_finish, m_job, m_pend_m;
    longint e_ratio, e_period;
    bit     e_rv, e_locked;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint ref_ratio(input longint m);
        longint q;
        q = ((longint'(1) << 24) * K + m / 2) / m;
        return (q > 64'hFF_FFFF) ? 64'hFF_FFFF : q;
    endfunction

    task automatic drop_lock(input bit clear_window);
        m_have_prev = 1'b0;
        m_lock_cnt  = 0;
        e_locked    = 1'b0;
        if (clear_window) begin
            m_win_sum = 0;
            m_win_n   = 0;
        end
    endtask

    task automatic model_edge(input bit v, input bit rst);
        bit ovf   = 1'b0;
        bit m_new = 1'b0;
        int m     = 0;
        int d;
        e_rv = 1'b0;
        if (rst) begin
            m_armed  = 1'b0; m_close = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            drop_lock(1'b1);
            e_ratio  = 0;
            e_period = 0;
        end else begin
            if (m_close) begin
                m_close = 1'b0;
                if (m_close_n < MIN_PERIOD) begin
                    drop_lock(1'b0);
                end else begin
                    m_win_sum += m_close_n;
                    m_win_n++;
                    if (m_win_sum >= (1 << 24)) begin
                        ovf     = 1'b1;
                        m_armed = 1'b0;
                        drop_lock(1'b1);
                    end else if (m_win_n == K) begin
                        m_new     = 1'b1;
                        m         = m_win_sum;
                        m_win_sum = 0;
                        m_win_n   = 0;
                    end
                end
            end
            if (!ovf) begin
                if (v && !m_armed) begin
                    m_armed = 1'b1;
                    m_last  = cyc;
                end else if (v) begin
                    m_close   = 1'b1;
                    m_close_n = cyc - m_last;
                    m_last    = cyc;
                end else if (m_armed && (cyc - m_last == MAX_PERIOD)) begin
                    m_armed = 1'b0;
                    drop_lock(1'b1);
                end
            end
            if (m_new) begin
                d = (m > m_prev) ? m - m_prev : m_prev - m;
                if (!m_have_prev || d > TOL) m_lock_cnt = 0;
                else if (m_lock_cnt < LOCK_COUNT) m_lock_cnt++;
                m_have_prev = 1'b1;
                m_prev      = m;
                e_period    = m;
                e_locked    = (m_lock_cnt == LOCK_COUNT);
                if (m_busy) begin
                    m_pend   = 1'b1;
                    m_pend_m = m;
                end else begin
                    m_busy   = 1'b1;
                    m_job    = m;
                    m_finish = cyc + 27;
                end
            end
            if (m_busy && cyc == m_finish) begin
                e_rv    = 1'b1;
                e_ratio = ref_ratio(m_job);
                if (m_pend) begin
                    m_pend   = 1'b0;
                    m_job    = m_pend_m;
                    m_finish = cyc + 27;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input bit v);
        in_valid = v;
        @(posedge clk);
        model_edge(v, reset);
        #1;
        check("ratio_valid", ratio_valid, e_rv);
        check("ratio", ratio, e_ratio);
        check("locked", locked, e_locked);
        check("period", period, e_period);
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic strobes(input int per, input int cnt);
        repeat (cnt) begin
            gap(per - 1);
            step(1'b1);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        gap(3);
        reset = 1'b0;
        gap(2);

`ifndef UPSAMPLE_RATIO_AVG_EN
        strobes(64, 12);
        gap(30);
        check("lock_at_64", locked, 1);
        check("ratio_at_64", ratio, 262144);

        strobes(3, 12);
        gap(30);
        check("ratio_at_3", ratio, 5592405);
        strobes(1, 4);
        gap(30);
        check("reject_unlock", locked, 0);
        check("reject_keeps_ratio", ratio, 5592405);

        strobes(64, 12);
        gap(MAX_PERIOD + 20);
        check("timeout_unlock", locked, 0);
        strobes(64, 10);
        gap(2);
        check("relock_after_9", locked, 1);

        strobes(10, 40);
        gap(60);
        check("ratio_at_10", ratio, 1677722);
`else
        strobes(100, 1);
        for (int i = 0; i < 48; i++) strobes((i % 2 == 0) ? 100 : 101, 1);
        gap(40);
        check("avg_period", period, 1608);
        check("avg_ratio", ratio, 166937);
`endif

        strobes(MAX_PERIOD, 4);
        strobes(MAX_PERIOD + 1, 3);
        strobes(MAX_PERIOD - 1, 3);

        pulse_reset();
        strobes(64, 2);
        gap(12);
        pulse_reset();
        check("reset_ratio", ratio, 0);
        gap(60);
        strobes(64, 2);
        gap(40);

        for (int seg = 0; seg < 25; seg++) begin
            int base;
            int cnt;
            base = $urandom_range(1, 70);
            cnt  = $urandom_range(3, 14);
            for (int k = 0; k < cnt; k++) begin
                if ($urandom_range(0, 15) == 0) strobes($urandom_range(MAX_PERIOD - 2, MAX_PERIOD + 5), 1);
                else strobes(base + $urandom_range(0, TOL + 1), 1);
            end
            if ($urandom_range(0, 9) == 0) begin
                gap($urandom_range(0, 30));
                pulse_reset();
            end
        end
        gap(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
